// File: rtl/uart_temp_rx.sv
// Receiver for the 50-bit temperature UART frame: start, 32-bit count LSB first,
// 16-bit CRLF trailer LSB first, stop. The count is presented with a one-cycle valid strobe.
module uart_temp_rx #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [15:0] CRLF_WORD    = 16'h0D0A
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  uart_rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  frame_err_o,
    output logic                  crlf_err_o,
    output logic                  busy_o
);

    localparam int             TW         = $clog2(CLKS_PER_BIT);
    localparam int             IW         = 6;
    localparam logic [TW-1:0]  MID_CNT    = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  END_CNT    = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]  DATA_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0]  TRAIL_LAST = IW'(15);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_TRAIL, S_STOP, S_BREAK
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic                  r_rx_d;
    logic [TW-1:0]         r_bit_timer;
    logic [IW-1:0]         r_bit_idx;
    logic [DATA_WIDTH-1:0] r_data_sr;
    logic [15:0]           r_crlf_sr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_ferr;
    logic                  r_cerr;
    logic                  w_fall;
    logic                  w_mid;
    logic                  w_end;
    logic                  w_crlf_ok;

    // Synchroniser flops reset to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    assign w_fall    = r_rx_d & ~r_rx_s;
    assign w_mid     = (r_bit_timer == MID_CNT);
    assign w_end     = (r_bit_timer == END_CNT);
    assign w_crlf_ok = (r_crlf_sr == CRLF_WORD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_next = S_START;
            S_START: if (w_mid) w_next = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_end && r_bit_idx == DATA_LAST) w_next = S_TRAIL;
            S_TRAIL: if (w_end && r_bit_idx == TRAIL_LAST) w_next = S_STOP;
            S_STOP:  if (w_end) w_next = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (r_rx_s) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Timer restarts on every state change so START->DATA re-aligns sampling to mid-bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_timer <= '0;
        end else if (r_state == S_IDLE || r_state == S_BREAK || w_next != r_state || w_end) begin
            r_bit_timer <= '0;
        end else begin
            r_bit_timer <= r_bit_timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_idx <= '0;
        end else if (r_state == S_START) begin
            r_bit_idx <= '0;
        end else if ((r_state == S_DATA || r_state == S_TRAIL) && w_end) begin
            r_bit_idx <= (w_next != r_state) ? '0 : r_bit_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_end && r_state == S_DATA)  r_data_sr <= {r_rx_s, r_data_sr[DATA_WIDTH-1:1]};
        if (w_end && r_state == S_TRAIL) r_crlf_sr <= {r_rx_s, r_crlf_sr[15:1]};
    end

    // Result pulses are registered from the stop-bit sample point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_cerr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_cerr  <= 1'b0;
            if (r_state == S_STOP && w_end) begin
                r_valid <= r_rx_s & w_crlf_ok;
                r_ferr  <= ~r_rx_s;
                r_cerr  <= ~w_crlf_ok;
                if (r_rx_s && w_crlf_ok) r_data <= r_data_sr;
            end
        end
    end

    assign data_o       = r_data;
    assign data_valid_o = r_valid;
    assign frame_err_o  = r_ferr;
    assign crlf_err_o   = r_cerr;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_temp_rx.sv
// Directed-plus-random bench for uart_temp_rx using a shortened bit period so every
// frame-level scenario fits a short run; frames are built from the line-format rules.
module tb_uart_temp_rx;

    localparam int          DW   = 32;
    localparam int          CPB  = 128;
    localparam int          H    = CPB / 2;
    localparam logic [15:0] CRLF = 16'h0D0A;
    localparam int          LAT  = (H - 1) + 49 * CPB + 1 + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          uart_rx_i = 1'b1;
    logic [DW-1:0] data_o;
    logic          data_valid_o;
    logic          frame_err_o;
    logic          crlf_err_o;
    logic          busy_o;

    uart_temp_rx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .CRLF_WORD   (CRLF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart_rx_i   (uart_rx_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .frame_err_o (frame_err_o),
        .crlf_err_o  (crlf_err_o),
        .busy_o      (busy_o)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_valid = 0;
    int            n_ferr  = 0;
    int            n_cerr  = 0;
    int            n_busy  = 0;
    int            vtime[$];
    logic [DW-1:0] vdata[$];

    always @(negedge clk) begin
        if (data_valid_o) begin
            n_valid++;
            vtime.push_back(cyc);
            vdata.push_back(data_o);
        end
        if (frame_err_o) n_ferr++;
        if (crlf_err_o)  n_cerr++;
        if (busy_o)      n_busy++;
    end

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_data = '0;
    int            exp_nv = 0;
    int            exp_nf = 0;
    int            exp_nc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [DW-1:0] d, input logic [15:0] tr, input logic stopb,
                             input int per, input int nbits, output int t_drop);
        logic [49:0] fr;
        fr = {stopb, tr, d, 1'b0};
        t_drop = cyc;
        for (int k = 0; k < nbits; k++) begin
            uart_rx_i = fr[k];
            repeat (per) @(negedge clk);
        end
    endtask

    // Reference model: a frame is accepted only with a high stop bit and the exact trailer.
    task automatic send_frame(input logic [DW-1:0] d, input logic [15:0] tr, input logic stopb,
                              input int per, output int t_drop);
        send_bits(d, tr, stopb, per, 50, t_drop);
        if (stopb && tr == CRLF) begin
            exp_nv++;
            exp_data = d;
        end
        if (!stopb)     exp_nf++;
        if (tr != CRLF) exp_nc++;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_valid_cnt"}, 64'(n_valid), 64'(exp_nv));
        check({tag, "_ferr_cnt"},  64'(n_ferr),  64'(exp_nf));
        check({tag, "_cerr_cnt"},  64'(n_cerr),  64'(exp_nc));
        check({tag, "_data"},      64'(data_o),  64'(exp_data));
    endtask

    initial begin
        int t0;
        int t1;
        int lat;
        int busy0;
        logic [DW-1:0] rd;

        repeat (5) @(negedge clk);
        check("rst_data",  64'(data_o), 64'd0);
        check("rst_valid", 64'(data_valid_o), 64'd0);
        check("rst_ferr",  64'(frame_err_o), 64'd0);
        check("rst_cerr",  64'(crlf_err_o), 64'd0);
        check("rst_busy",  64'(busy_o), 64'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame and latency
        send_frame(32'h0000_1234, CRLF, 1'b1, CPB, t0);
        repeat (4) @(negedge clk);
        lat = vtime.size() > 0 ? vtime[$] - t0 : -1;
        check("t1_latency_window", 64'(lat >= LAT - 2 && lat <= LAT + 2), 64'd1);
        check_counts("t1");
        check("t1_busy_after", 64'(busy_o), 64'd0);

        // Back-to-back frames, zero idle gap
        send_frame(32'hFFFF_FFFF, CRLF, 1'b1, CPB, t0);
        send_frame(32'h8000_0001, CRLF, 1'b1, CPB, t1);
        repeat (4) @(negedge clk);
        check_counts("t2");
        check("t2_first_data", 64'(vdata.size() > 1 ? vdata[vdata.size()-2] : '0), 64'hFFFF_FFFF);
        check("t2_spacing", 64'(vtime.size() > 1 ? vtime[vtime.size()-1] - vtime[vtime.size()-2] : 0),
              64'(50 * CPB));

        // Short low glitch: START times out on a high mid-bit sample
        busy0 = n_busy;
        uart_rx_i = 1'b0;
        repeat (H / 2) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("t3_busy_cycles", 64'(n_busy - busy0), 64'(H));
        check_counts("t3");

        // Stop bit low, then line held low (break)
        send_frame(32'hA5A5_A5A5, CRLF, 1'b0, CPB, t0);
        repeat (2000) @(negedge clk);
        check_counts("t4");
        check("t4_busy_in_break", 64'(busy_o), 64'd1);
        uart_rx_i = 1'b1;
        repeat (8) @(negedge clk);
        check("t4_busy_released", 64'(busy_o), 64'd0);
        rd = $urandom;
        send_frame(rd, CRLF, 1'b1, CPB, t0);
        repeat (4) @(negedge clk);
        check_counts("t4_recover");

        // Bad trailer, then reset in the middle of data bit 10
        send_frame(32'h1357_9BDF, 16'h0D0B, 1'b1, CPB, t0);
        repeat (4) @(negedge clk);
        check_counts("t5_crlf");
        rd = 32'hDEAD_BEEF;
        send_bits(rd, CRLF, 1'b1, CPB, 11, t0);
        uart_rx_i = rd[10];
        repeat (H) @(negedge clk);
        check("t5_busy_mid_frame", 64'(busy_o), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        exp_data = '0;
        check("t5_rst_data",  64'(data_o), 64'd0);
        check("t5_rst_busy",  64'(busy_o), 64'd0);
        check("t5_rst_flags", 64'({data_valid_o, frame_err_o, crlf_err_o}), 64'd0);
        uart_rx_i = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_counts("t5_after_rst");
        send_frame(32'h0000_0042, CRLF, 1'b1, CPB, t0);
        repeat (4) @(negedge clk);
        check_counts("t5_recover");

        // Transmitter clock mismatch of about 0.8 percent either way, random payloads
        for (int p = 0; p < 2; p++) begin
            for (int f = 0; f < 2; f++) begin
                rd = $urandom;
                send_frame(rd, CRLF, 1'b1, (p == 0) ? CPB - 1 : CPB + 1, t0);
                repeat (2) @(negedge clk);
                check($sformatf("t6_p%0d_f%0d_data", p, f), 64'(data_o), 64'(rd));
            end
        end
        repeat (4) @(negedge clk);
        check_counts("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
